// File: rtl/demux_pkg.sv
// demux_pkg: shared types and default sizes for the 1-to-2 demultiplexer.
package demux_pkg;

  // Occupancy of a one-entry output slot.
  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output buffer with valid/ready handshake.
// A push and a pop at the same edge keep the slot full with the new word.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             accept
);

  slot_state_e      state_r;
  slot_state_e      state_s;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] data_s;
  logic             pop_s;

  assign pop_s     = (state_r == SLOT_FULL) & out_ready;
  // Room exists if the slot is empty or its word leaves this cycle.
  assign accept    = (state_r == SLOT_EMPTY) | out_ready;
  assign out_valid = (state_r == SLOT_FULL);
  assign out_data  = data_r;

  // Next-state and next-data selection: push wins over pop.
  always_comb begin
    state_s = state_r;
    data_s  = data_r;
    if (push) begin
      state_s = SLOT_FULL;
      data_s  = din;
    end else if (pop_s) begin
      state_s = SLOT_EMPTY;
    end else begin
      state_s = state_r;
      data_s  = data_r;
    end
  end

  // Slot state and data registers; reset clears both.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SLOT_EMPTY;
      data_r  <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      data_r  <= data_s;
    end
  end

endmodule

// File: rtl/demux_1x2_4.sv
// demux_1x2_4: routes a valid/ready word stream to one of two buffered ports.
// Optional per-port transfer counters are built when DEMUX_COUNT_EN is defined;
// otherwise cnt0/cnt1 are tied to zero.
module demux_1x2_4
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic             out0_valid,
  output logic             out1_valid,
  input  logic             out0_ready,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic accept0_s;
  logic accept1_s;
  logic push0_s;
  logic push1_s;

  // in_ready depends only on sel and the selected port's slot.
  assign in_ready = sel ? accept1_s : accept0_s;
  assign push0_s  = in_valid & in_ready & ~sel;
  assign push1_s  = in_valid & in_ready & sel;

  demux_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0_s),
    .din       (in_data),
    .out_ready (out0_ready),
    .out_data  (out0_data),
    .out_valid (out0_valid),
    .accept    (accept0_s)
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1_s),
    .din       (in_data),
    .out_ready (out1_ready),
    .out_data  (out1_data),
    .out_valid (out1_valid),
    .accept    (accept1_s)
  );

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;

  // Accepted-word counters per port, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_r <= {CNT_W{1'b0}};
      cnt1_r <= {CNT_W{1'b0}};
    end else begin
      if (push0_s) begin
        cnt0_r <= cnt0_r + CNT_W'(1'b1);
      end else begin
        cnt0_r <= cnt0_r;
      end
      if (push1_s) begin
        cnt1_r <= cnt1_r + CNT_W'(1'b1);
      end else begin
        cnt1_r <= cnt1_r;
      end
    end
  end

  assign cnt0 = cnt0_r;
  assign cnt1 = cnt1_r;
`else
  assign cnt0 = {CNT_W{1'b0}};
  assign cnt1 = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_demux_1x2_4.sv
// tb_demux_1x2_4: table-driven and scoreboard checks for demux_1x2_4.
module tb_demux_1x2_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic       sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out0_data;
  logic [3:0] out1_data;
  logic       out0_valid;
  logic       out1_valid;
  logic       out0_ready;
  logic       out1_ready;
  logic [7:0] cnt0;
  logic [7:0] cnt1;

  demux_1x2_4 dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .sel        (sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out1_data  (out1_data),
    .out0_valid (out0_valid),
    .out1_valid (out1_valid),
    .out0_ready (out0_ready),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of both slots plus delivery scoreboards.
  logic [1:0] m_full;
  logic [3:0] m_data [2];
  logic [7:0] m_cnt  [2];
  logic [3:0] q0 [$];
  logic [3:0] q1 [$];
  logic       rdy_seen;

  typedef struct {
    logic       r;
    logic [3:0] d;
    logic       s;
    logic       v;
    logic       r0;
    logic       r1;
    logic       rdy;
    logic       v0;
    logic [3:0] d0;
    logic       v1;
    logic [3:0] d1;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_full    = 2'b00;
    m_data[0] = 4'd0;
    m_data[1] = 4'd0;
    m_cnt[0]  = 8'd0;
    m_cnt[1]  = 8'd0;
    q0.delete();
    q1.delete();
  endtask

  task automatic step(input logic r, input logic [3:0] d, input logic s, input logic v,
                      input logic rd0, input logic rd1);
    logic       exp_rdy;
    logic       pop0;
    logic       pop1;
    logic       push;
    logic [3:0] w;
    logic [7:0] ec0;
    logic [7:0] ec1;
    @(negedge clk);
    rst = r; in_data = d; sel = s; in_valid = v; out0_ready = rd0; out1_ready = rd1;
    #1;
    exp_rdy  = s ? (!m_full[1] || rd1) : (!m_full[0] || rd0);
    rdy_seen = in_ready;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    pop0 = m_full[0] && rd0;
    pop1 = m_full[1] && rd1;
    push = v && exp_rdy;
    if (!r) begin
      if (pop0 && q0.size() > 0) begin
        w = q0.pop_front();
        chk("deliver0", {28'd0, out0_data}, {28'd0, w});
      end
      if (pop1 && q1.size() > 0) begin
        w = q1.pop_front();
        chk("deliver1", {28'd0, out1_data}, {28'd0, w});
      end
    end
    @(posedge clk);
    if (r) begin
      model_clear();
    end else begin
      if (pop0) m_full[0] = 1'b0;
      if (pop1) m_full[1] = 1'b0;
      if (push) begin
        m_full[s] = 1'b1;
        m_data[s] = d;
        m_cnt[s]  = m_cnt[s] + 8'd1;
        if (s) q1.push_back(d); else q0.push_back(d);
      end
    end
    #1;
`ifdef DEMUX_COUNT_EN
    ec0 = m_cnt[0];
    ec1 = m_cnt[1];
`else
    ec0 = 8'd0;
    ec1 = 8'd0;
`endif
    chk("out0_valid", {31'd0, out0_valid}, {31'd0, m_full[0]});
    chk("out1_valid", {31'd0, out1_valid}, {31'd0, m_full[1]});
    chk("out0_data", {28'd0, out0_data}, {28'd0, m_data[0]});
    chk("out1_data", {28'd0, out1_data}, {28'd0, m_data[1]});
    chk("cnt0", {24'd0, cnt0}, {24'd0, ec0});
    chk("cnt1", {24'd0, cnt1}, {24'd0, ec1});
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //          r     d        s     v     r0    r1    rdy   v0    d0       v1    d1
    tbl[0] = '{1'b0, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b0, 4'b0000};
    tbl[1] = '{1'b0, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0, 4'b0000};
    tbl[2] = '{1'b0, 4'b0101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b1, 4'b0101};
    tbl[3] = '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1010, 1'b1, 4'b1111};
    tbl[4] = '{1'b0, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1010, 1'b1, 4'b0011};
    tbl[5] = '{1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b1, 4'b0011};
    tbl[6] = '{1'b1, 4'b0110, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000};
    tbl[7] = '{1'b0, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0111};
    tbl[8] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0111};

    rst = 1'b1; in_data = 4'd0; sel = 1'b0; in_valid = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
    chk("rst_out0_data", {28'd0, out0_data}, 32'd0);
    chk("rst_cnt0", {24'd0, cnt0}, 32'd0);

    // Directed vectors: first push, stall, side-port push, push+pop, reset override.
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].r, tbl[i].d, tbl[i].s, tbl[i].v, tbl[i].r0, tbl[i].r1);
      chk($sformatf("tbl%0d_rdy", i), {31'd0, rdy_seen}, {31'd0, tbl[i].rdy});
      chk($sformatf("tbl%0d_v0", i), {31'd0, out0_valid}, {31'd0, tbl[i].v0});
      chk($sformatf("tbl%0d_d0", i), {28'd0, out0_data}, {28'd0, tbl[i].d0});
      chk($sformatf("tbl%0d_v1", i), {31'd0, out1_valid}, {31'd0, tbl[i].v1});
      chk($sformatf("tbl%0d_d1", i), {28'd0, out1_data}, {28'd0, tbl[i].d1});
    end

    // Counter wrap: 257 pushes to port 0 with downstream always ready.
    step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 257; i++) begin
      step(1'b0, 4'(i), 1'b0, 1'b1, 1'b1, 1'b0);
    end
`ifdef DEMUX_COUNT_EN
    chk("cnt0_wrap", {24'd0, cnt0}, 32'd1);
`else
    chk("cnt0_wrap", {24'd0, cnt0}, 32'd0);
`endif
    chk("cnt1_wrap", {24'd0, cnt1}, 32'd0);

    // Alternating destinations with both ports draining every cycle.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 4'($urandom_range(15)), i[0], 1'b1, 1'b1, 1'b1);
    end
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Random traffic with occasional resets and back-pressure.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(31) == 0), 4'($urandom_range(15)), 1'($urandom_range(1)),
           1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
